mult_add_divider: RTL and testbench
===================================

# mult_add_divider

Iterative signed divider: the inverse of the team's multiply-add datapath (p = a*b + c). It takes a dividend `p` and a divisor `b` and recovers a quotient `q` and remainder `r` such that p = q*b + r. It uses radix-2 restoring division, one quotient bit per cycle. It sits beside the DSP multiply-add units wherever a result must be decomposed back into multiplier and addend terms, behind valid/ready handshakes on both sides.

## Interface
- `PWIDTH`, 33: dividend and quotient width (signed).
- `BWIDTH`, 16: divisor and remainder width (signed); must be ≤ PWIDTH.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: global enable; low freezes all state and outputs.
- `in_valid` input 1: operand valid.
- `in_ready` output 1: block can accept operands.
- `p` input PWIDTH: signed dividend.
- `b` input BWIDTH: signed divisor.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `q` output PWIDTH: signed quotient.
- `r` output BWIDTH: signed remainder.
- `div_by_zero` output 1: result is from a zero divisor.
- `overflow` output 1: quotient wrapped (most-negative / -1).

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
  - **IDLE**: `in_ready`=1. If `in_valid`&`en`, capture `p` and `b`, then go to PREP.
  - **PREP**: store the absolute values of both operands, the quotient sign (sign(p) xor sign(b)), the remainder sign (sign(p)), and the `div_by_zero`/`overflow` flags. Load the iteration counter with PWIDTH-1. Go to CALC.
  - **CALC**: each cycle, shift the partial remainder left by 1 and bring in the next dividend MSB. Trial-subtract |b|. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0. When counter==0, go to FIX; otherwise decrement the counter.
  - **FIX**: apply the signs.
    - q = quotient negated if the quotient sign is 1.
    - r = remainder negated if the remainder sign is 1.
    - Load the output registers. Go to DONE.
  - **DONE**: `out_valid`=1. On `out_ready`&`en`, go to IDLE.
- Arithmetic:
  - Truncation toward zero; the remainder takes the dividend's sign; |r| < |b|.
  - Partial remainder register is BWIDTH+1 bits; |p| magnitude register is PWIDTH bits, unsigned. This covers |−2^(PWIDTH−1)|.
- Divide by zero (b==0): iterations still run, for constant latency. FIX forces q = all ones (−1), r = 0, `div_by_zero`=1.
- Overflow (p == −2^(PWIDTH−1) and b == −1): q = −2^(PWIDTH−1) (wrapped), r = 0, `overflow`=1.
- `in_ready` is high only in IDLE. There is no accept in the same cycle a result drains; the next operand is taken on the earliest the following cycle.
- `en` low: state, counter, datapath and outputs all hold, in every state. Handshakes are ignored, so `en`=0 with `out_ready`=1 does not drain the result.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE; `in_ready`=1.
  - `out_valid`=0; q=0; r=0; `div_by_zero`=0; `overflow`=0; internal registers=0.
  - Reset mid-operation discards the operation; no result is produced.
- Latency: the accept edge is T0. `out_valid` rises after edge T0+PWIDTH+2: 1 PREP cycle + PWIDTH CALC cycles + 1 FIX cycle. This is 35 cycles at the defaults and is constant for all operands, including zero and overflow cases. Every `en`=0 cycle extends it by one.
- q, r, `div_by_zero` and `overflow` are stable for the whole DONE interval. They update only in FIX.
- `in_ready` falls the cycle after accept. It rises the cycle after the `out_valid`&`out_ready`&`en` edge.
- Minimum issue interval: PWIDTH+4 cycles.

## Test plan
- **Positive/positive:** p=100, b=7 → q=14, r=2, flags 0; `out_valid` exactly 35 cycles after the accept edge.
- **Sign combinations:**
  - p=−100, b=7 → q=−14, r=−2.
  - p=100, b=−7 → q=−14, r=2.
  - p=−100, b=−7 → q=14, r=−2.
- **Extremes:**
  - p=12345, b=0 → q=−1 (all ones), r=0, `div_by_zero`=1.
  - p=−2^32, b=−1 → q=−2^32, r=0, `overflow`=1.
  - p=2^32−1, b=−32768 → q=−131071, r=32767.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles in DONE → q, r and flags stable and `in_ready`=0 throughout. Raise `out_ready` → `in_ready`=1 on the next cycle. A second operand offered during DONE is not accepted.
- **Enable stall:** drop `en` for 5 cycles mid-CALC with p=1000, b=3 → result q=333, r=1 arrives 5 cycles late. No output changes during the stall.
- **Reset mid-operation:** assert `rst_n`=0 at CALC iteration 10 → outputs immediately take their reset values (asynchronous), `in_ready`=1 after release. A fresh p=50, b=5 gives q=10, r=0 with normal latency.

Source files
------------

// File: rtl/mult_add_divider.sv
// Iterative signed divider: recovers q and r from p = q*b + r using radix-2
// restoring division, one quotient bit per cycle, with valid/ready on both sides.
module mult_add_divider #(
   parameter int PWIDTH = 33,
   parameter int BWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PWIDTH-1:0] p,
   input  logic [BWIDTH-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PWIDTH-1:0] q,
   output logic [BWIDTH-1:0] r,
   output logic              div_by_zero,
   output logic              overflow
);

   localparam int CW = $clog2(PWIDTH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t              state_r;
   logic [PWIDTH-1:0]   p_cap_r;
   logic [BWIDTH-1:0]   b_cap_r;
   logic [PWIDTH-1:0]   mag_p_r;
   logic [BWIDTH-1:0]   mag_b_r;
   logic [BWIDTH:0]     rem_r;
   logic [CW-1:0]       cnt_r;
   logic                qsign_r;
   logic                rsign_r;
   logic                dbz_r;
   logic                ovf_r;
   logic                in_ready_r;
   logic                out_valid_r;
   logic [PWIDTH-1:0]   q_r;
   logic [BWIDTH-1:0]   r_r;
   logic                div_by_zero_r;
   logic                overflow_r;

   logic [BWIDTH+1:0]   diff_s;
   logic [BWIDTH:0]     restore_s;
   logic [PWIDTH-1:0]   neg_q_s;
   logic [BWIDTH-1:0]   neg_r_s;

   // Trial subtraction and sign-application datapath.
   // mag_p_r doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom.
   always_comb begin
      diff_s    = {rem_r, mag_p_r[PWIDTH-1]} - {2'b00, mag_b_r};
      restore_s = {rem_r[BWIDTH-1:0], mag_p_r[PWIDTH-1]};
      neg_q_s   = '0 - mag_p_r;
      neg_r_s   = '0 - rem_r[BWIDTH-1:0];
   end

   // Control FSM with all datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         p_cap_r       <= '0;
         b_cap_r       <= '0;
         mag_p_r       <= '0;
         mag_b_r       <= '0;
         rem_r         <= '0;
         cnt_r         <= '0;
         qsign_r       <= 1'b0;
         rsign_r       <= 1'b0;
         dbz_r         <= 1'b0;
         ovf_r         <= 1'b0;
         in_ready_r    <= 1'b1;
         out_valid_r   <= 1'b0;
         q_r           <= '0;
         r_r           <= '0;
         div_by_zero_r <= 1'b0;
         overflow_r    <= 1'b0;
      end else if (en) begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  p_cap_r    <= p;
                  b_cap_r    <= b;
                  in_ready_r <= 1'b0;
                  state_r    <= PREP;
               end
            end
            PREP: begin
               mag_p_r <= p_cap_r[PWIDTH-1] ? ('0 - p_cap_r) : p_cap_r;
               mag_b_r <= b_cap_r[BWIDTH-1] ? ('0 - b_cap_r) : b_cap_r;
               qsign_r <= p_cap_r[PWIDTH-1] ^ b_cap_r[BWIDTH-1];
               rsign_r <= p_cap_r[PWIDTH-1];
               dbz_r   <= (b_cap_r == '0);
               ovf_r   <= (p_cap_r == {1'b1, {(PWIDTH-1){1'b0}}}) && (b_cap_r == '1);
               rem_r   <= '0;
               cnt_r   <= CW'(PWIDTH - 1);
               state_r <= CALC;
            end
            CALC: begin
               if (!diff_s[BWIDTH+1]) begin
                  rem_r   <= diff_s[BWIDTH:0];
                  mag_p_r <= {mag_p_r[PWIDTH-2:0], 1'b1};
               end else begin
                  rem_r   <= restore_s;
                  mag_p_r <= {mag_p_r[PWIDTH-2:0], 1'b0};
               end
               if (cnt_r == '0) begin
                  state_r <= FIX;
               end else begin
                  cnt_r <= cnt_r - CW'(1);
               end
            end
            FIX: begin
               if (dbz_r) begin
                  q_r <= '1;
                  r_r <= '0;
               end else if (ovf_r) begin
                  q_r <= {1'b1, {(PWIDTH-1){1'b0}}};
                  r_r <= '0;
               end else begin
                  q_r <= qsign_r ? neg_q_s : mag_p_r;
                  r_r <= rsign_r ? neg_r_s : rem_r[BWIDTH-1:0];
               end
               div_by_zero_r <= dbz_r;
               overflow_r    <= ovf_r;
               out_valid_r   <= 1'b1;
               state_r       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign q           = q_r;
   assign r           = r_r;
   assign div_by_zero = div_by_zero_r;
   assign overflow    = overflow_r;

endmodule

// File: tb/tb_mult_add_divider.sv
// Self-checking bench for mult_add_divider: directed table, corner sequences and
// random operands checked against a plain-arithmetic reference model.
module tb_mult_add_divider;

   localparam int PW = 33;
   localparam int BW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          en = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [PW-1:0] p = '0;
   logic [BW-1:0] b = '0;
   logic          in_ready;
   logic          out_valid;
   logic [PW-1:0] q;
   logic [BW-1:0] r;
   logic          div_by_zero;
   logic          overflow;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int t0 = 0;

   typedef struct {
      string         nm;
      logic [PW-1:0] vp;
      logic [BW-1:0] vb;
      logic [PW-1:0] eq;
      logic [BW-1:0] er;
      logic          edz;
      logic          eov;
   } vec_t;

   vec_t vecs[7];

   mult_add_divider #(.PWIDTH(PW), .BWIDTH(BW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .p(p), .b(b), .out_valid(out_valid), .out_ready(out_ready), .q(q), .r(r),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain signed division, truncating toward zero.
   function automatic void model(input logic signed [PW-1:0] pp, input logic signed [BW-1:0] bb,
                                 output logic [PW-1:0] eq, output logic [BW-1:0] er,
                                 output logic edz, output logic eov);
      longint pl = pp;
      longint bl = bb;
      if (bl == 0) begin
         eq = '1; er = '0; edz = 1'b1; eov = 1'b0;
      end else begin
         eq  = PW'(pl / bl);
         er  = BW'(pl % bl);
         edz = 1'b0;
         eov = (pl == -(longint'(1) << (PW - 1))) && (bl == -1);
      end
   endfunction

   task automatic issue(input logic [PW-1:0] pp, input logic [BW-1:0] bb);
      int g = 0;
      while (!in_ready && g < 100) begin step(); g++; end
      chk("accept_ready", 64'(in_ready), 64'(1'b1));
      p = pp; b = bb; in_valid = 1'b1;
      step();
      t0 = cyc;
      in_valid = 1'b0;
      chk("ready_fall", 64'(in_ready), 64'(1'b0));
   endtask

   task automatic wait_done(input int exp_lat);
      int g = 0;
      while (!out_valid && g < 200) begin step(); g++; end
      chk("latency", 64'(cyc - t0), 64'(exp_lat));
   endtask

   task automatic check_res(input string nm, input logic [PW-1:0] eq, input logic [BW-1:0] er,
                            input logic edz, input logic eov);
      chk({nm, ".q"}, 64'(q), 64'(eq));
      chk({nm, ".r"}, 64'(r), 64'(er));
      chk({nm, ".dz"}, 64'(div_by_zero), 64'(edz));
      chk({nm, ".ov"}, 64'(overflow), 64'(eov));
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("ready_rise", 64'(in_ready), 64'(1'b1));
      chk("valid_fall", 64'(out_valid), 64'(1'b0));
   endtask

   initial begin
      logic [PW-1:0] eq, hold_q;
      logic [BW-1:0] er, hold_r;
      logic          edz, eov;
      logic [31:0]   rv;
      logic [BW-1:0] rb;

      vecs[0] = '{"pos_pos",  33'd100,          16'd7,      33'd14,           16'd2,     1'b0, 1'b0};
      vecs[1] = '{"neg_pos",  -33'sd100,        16'd7,      -33'sd14,         -16'sd2,   1'b0, 1'b0};
      vecs[2] = '{"pos_neg",  33'd100,          -16'sd7,    -33'sd14,         16'd2,     1'b0, 1'b0};
      vecs[3] = '{"neg_neg",  -33'sd100,        -16'sd7,    33'd14,           -16'sd2,   1'b0, 1'b0};
      vecs[4] = '{"div_zero", 33'd12345,        16'd0,      33'h1_FFFF_FFFF,  16'd0,     1'b1, 1'b0};
      vecs[5] = '{"ovf",      33'h1_0000_0000,  16'hFFFF,   33'h1_0000_0000,  16'd0,     1'b0, 1'b1};
      vecs[6] = '{"max_min",  33'h0_FFFF_FFFF,  16'h8000,   -33'sd131071,     16'd32767, 1'b0, 1'b0};

      #2 rst_n = 1'b0;
      step(); step();
      chk("rst.in_ready", 64'(in_ready), 64'(1'b1));
      chk("rst.out_valid", 64'(out_valid), 64'(1'b0));
      check_res("rst", '0, '0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 7; i++) begin
         issue(vecs[i].vp, vecs[i].vb);
         wait_done(35);
         check_res(vecs[i].nm, vecs[i].eq, vecs[i].er, vecs[i].edz, vecs[i].eov);
         drain();
      end

      // Back-pressure: result held, competing operand ignored, en=0 blocks drain.
      issue(33'd1000000, 16'd123);
      wait_done(35);
      model(33'd1000000, 16'd123, eq, er, edz, eov);
      for (int i = 0; i < 10; i++) begin
         p = 33'd7; b = 16'd1; in_valid = 1'b1;
         step();
         chk("bp.out_valid", 64'(out_valid), 64'(1'b1));
         chk("bp.in_ready", 64'(in_ready), 64'(1'b0));
         check_res("bp", eq, er, edz, eov);
      end
      in_valid = 1'b0;
      en = 1'b0; out_ready = 1'b1;
      step(); step();
      chk("en0_no_drain", 64'(out_valid), 64'(1'b1));
      en = 1'b1;
      drain();
      step();
      chk("bp.not_taken", 64'(in_ready), 64'(1'b1));

      // Enable stall mid-CALC.
      hold_q = q; hold_r = r;
      issue(33'd1000, 16'd3);
      for (int i = 0; i < 10; i++) step();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall.out_valid", 64'(out_valid), 64'(1'b0));
         chk("stall.q", 64'(q), 64'(hold_q));
         chk("stall.r", 64'(r), 64'(hold_r));
      end
      en = 1'b1;
      wait_done(40);
      check_res("stall", 33'd333, 16'd1, 1'b0, 1'b0);
      drain();

      // Random operands against the reference model.
      for (int i = 0; i < 40; i++) begin
         rv = $urandom;
         case ($urandom_range(0, 4))
            0: rb = 16'(($urandom_range(0, 1) == 0) ? $urandom_range(1, 20) : -$urandom_range(1, 20));
            1: rb = 16'd0;
            2: rb = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h8000;
            default: rb = 16'($urandom);
         endcase
         p = {1'($urandom_range(0, 1)), rv};
         model(p, rb, eq, er, edz, eov);
         issue(p, rb);
         wait_done(35);
         check_res("rand", eq, er, edz, eov);
         drain();
      end

      // Reset mid-operation, then a fresh operation.
      issue(33'd99999, 16'd7);
      for (int i = 0; i < 11; i++) step();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst.out_valid", 64'(out_valid), 64'(1'b0));
      chk("mid_rst.in_ready", 64'(in_ready), 64'(1'b1));
      check_res("mid_rst", '0, '0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      chk("mid_rst.idle", 64'(out_valid), 64'(1'b0));
      issue(33'd50, 16'd5);
      wait_done(35);
      check_res("post_rst", 33'd10, 16'd0, 1'b0, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
